// File: rtl/dnn_train_sched.sv
// dnn_train_sched: training-schedule controller for the DNN datapath.
// Walks training-case indices and epochs, gates input feeding with
// start/pause, drains the result pipeline and reports per-epoch
// correct-answer counts.
// Optional build macro: SCHED_ETA_DECAY_EN enables the learning-rate
// exponent decay; without it etapos is the constant ETA_INIT.
//
// Feed handshake: feed_valid is the valid, and the DNN is always ready.
// A case counts as fed in every cycle that shows feed_valid=1 together
// with tc_idx. tc_idx moves past a case only after that case has been
// shown with feed_valid=1. While paused, tc_idx rests on the next unfed
// case with feed_valid=0.
//
// Result timing: the delay registers load from the same next-state values
// that launch tc_idx/feed_valid. The correct bit for a case is therefore
// sampled DRAIN clock edges after the edge that launched that case, and
// epoch_done is visible DRAIN cycles after the case's feed cycle.
module dnn_train_sched #(
    parameter int TC       = 12544,
    parameter int EPOCHS   = 10,
    parameter int DRAIN    = 2,
    parameter int ETA_W    = 4,
    parameter int ETA_INIT = 3,
    parameter int ETA_MAX  = 7,
    parameter int ETA_STEP = 2,
    localparam int TC_W    = (TC > 1) ? $clog2(TC) : 1,
    localparam int EP_W    = (EPOCHS > 1) ? $clog2(EPOCHS) : 1,
    localparam int CNT_W   = $clog2(TC + 1)
) (
    input  logic             cycle_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             correct,
    output logic [TC_W-1:0]  tc_idx,
    output logic [EP_W-1:0]  epoch,
    output logic [ETA_W-1:0] etapos,
    output logic             feed_valid,
    output logic             busy,
    output logic             done,
    output logic             epoch_done,
    output logic [CNT_W-1:0] epoch_correct,
    output logic [1:0]       dbg_state
);

    localparam int DC_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [TC_W-1:0] TC_LAST    = TC_W'(TC - 1);
    localparam logic [EP_W-1:0] EP_LAST    = EP_W'(EPOCHS - 1);
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TC_W-1:0]  tc_idx_q, tc_idx_d;
    logic [EP_W-1:0]  epoch_q, epoch_d;
    logic             feed_valid_q, feed_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             epoch_done_q, epoch_done_d;
    logic [CNT_W-1:0] epoch_correct_q, epoch_correct_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [DRAIN-1:0] vld_sr_q, vld_sr_d;
    logic [DRAIN-1:0] mrk_sr_q, mrk_sr_d;
`ifdef SCHED_ETA_DECAY_EN
    logic [ETA_W-1:0] etapos_q, etapos_d;
`endif

    // Next-state, counters, result accumulation and delay-line shifting
    always_comb begin
        state_d         = state_q;
        tc_idx_d        = tc_idx_q;
        epoch_d         = epoch_q;
        feed_valid_d    = 1'b0;
        busy_d          = busy_q;
        done_d          = done_q;
        drain_cnt_d     = drain_cnt_q;
        acc_d           = acc_q;
        epoch_correct_d = epoch_correct_q;
        epoch_done_d    = 1'b0;
        vld_sr_d        = '0;
        mrk_sr_d        = '0;
`ifdef SCHED_ETA_DECAY_EN
        etapos_d        = etapos_q;
`endif

        // A delayed valid case contributes its correct bit; the epoch's
        // last case also publishes the total and restarts the count.
        if (vld_sr_q[DRAIN-1]) begin
            if (mrk_sr_q[DRAIN-1]) begin
                epoch_correct_d = acc_q + CNT_W'(correct);
                acc_d           = '0;
                epoch_done_d    = 1'b1;
            end else begin
                acc_d = acc_q + CNT_W'(correct);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RUN;
                    tc_idx_d     = '0;
                    epoch_d      = '0;
                    feed_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    acc_d        = '0;
`ifdef SCHED_ETA_DECAY_EN
                    etapos_d     = ETA_W'(ETA_INIT);
`endif
                end
            end
            S_RUN: begin
                feed_valid_d = ~pause;
                // Advance only past a case that has actually been fed.
                if (feed_valid_q) begin
                    if (tc_idx_q == TC_LAST) begin
                        if (epoch_q == EP_LAST) begin
                            state_d      = S_DRAIN;
                            feed_valid_d = 1'b0;
                            drain_cnt_d  = '0;
                        end else begin
                            tc_idx_d = '0;
                            epoch_d  = epoch_q + EP_W'(1);
`ifdef SCHED_ETA_DECAY_EN
                            if ((((int'(epoch_q) + 1) % ETA_STEP) == 0) &&
                                (int'(etapos_q) < ETA_MAX)) begin
                                etapos_d = etapos_q + ETA_W'(1);
                            end
`endif
                        end
                    end else begin
                        tc_idx_d = tc_idx_q + TC_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Delay lines track the case being launched this edge.
        vld_sr_d[0] = feed_valid_d;
        mrk_sr_d[0] = feed_valid_d && (tc_idx_d == TC_LAST);
        for (int i = 1; i < DRAIN; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
            mrk_sr_d[i] = mrk_sr_q[i-1];
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge cycle_clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            tc_idx_q        <= '0;
            epoch_q         <= '0;
            feed_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            epoch_done_q    <= 1'b0;
            epoch_correct_q <= '0;
            acc_q           <= '0;
            drain_cnt_q     <= '0;
            vld_sr_q        <= '0;
            mrk_sr_q        <= '0;
`ifdef SCHED_ETA_DECAY_EN
            etapos_q        <= ETA_W'(ETA_INIT);
`endif
        end else begin
            state_q         <= state_d;
            tc_idx_q        <= tc_idx_d;
            epoch_q         <= epoch_d;
            feed_valid_q    <= feed_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            epoch_done_q    <= epoch_done_d;
            epoch_correct_q <= epoch_correct_d;
            acc_q           <= acc_d;
            drain_cnt_q     <= drain_cnt_d;
            vld_sr_q        <= vld_sr_d;
            mrk_sr_q        <= mrk_sr_d;
`ifdef SCHED_ETA_DECAY_EN
            etapos_q        <= etapos_d;
`endif
        end
    end

`ifdef SCHED_ETA_DECAY_EN
    assign etapos = etapos_q;
`else
    assign etapos = ETA_W'(ETA_INIT);
`endif

    assign tc_idx        = tc_idx_q;
    assign epoch         = epoch_q;
    assign feed_valid    = feed_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign epoch_done    = epoch_done_q;
    assign epoch_correct = epoch_correct_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dnn_train_sched.sv
// tb_dnn_train_sched: directed bench for dnn_train_sched with
// TC=4, EPOCHS=3, DRAIN=2, ETA_INIT=3, ETA_MAX=4, ETA_STEP=1.
// Each cycle the bench wakes 1 time unit after the rising edge, compares
// the outputs of that cycle, then sets the inputs sampled at the next edge.
module tb_dnn_train_sched;

    logic       cycle_clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       correct;
    logic [1:0] tc_idx;
    logic [1:0] epoch;
    logic [3:0] etapos;
    logic       feed_valid;
    logic       busy;
    logic       done;
    logic       epoch_done;
    logic [2:0] epoch_correct;
    logic [1:0] dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected sequence of an unpaused run, index 0 = first RUN cycle
    logic [1:0] run_tc [0:14] = '{0,1,2,3,0,1,2,3,0,1,2,3,3,3,3};
    logic [1:0] run_ep [0:14] = '{0,0,0,0,1,1,1,1,2,2,2,2,2,2,2};
    logic [0:14] run_fv   = 15'b111111111111000;
    logic [0:14] run_busy = 15'b111111111111110;
    logic [0:14] run_done = 15'b000000000000001;
    logic [0:14] run_ed   = 15'b000001000100010;

    // Expected sequence of a run paused for 3 cycles on tc_idx=3 of epoch 0
    logic [1:0] p_tc [0:17] = '{0,1,2,3,3,3,3,0,1,2,3,0,1,2,3,3,3,3};
    logic [1:0] p_ep [0:17] = '{0,0,0,0,0,0,0,1,1,1,1,2,2,2,2,2,2,2};
    logic [0:17] p_fv   = 18'b111000111111111000;
    logic [0:17] p_busy = 18'b111111111111111110;
    logic [0:17] p_done = 18'b000000000000000001;
    logic [0:17] p_ed   = 18'b000000001000100010;

    // Learning-rate exponent per epoch
`ifdef SCHED_ETA_DECAY_EN
    logic [3:0] eta_by_ep [0:2] = '{4'd3, 4'd4, 4'd4};
`else
    logic [3:0] eta_by_ep [0:2] = '{4'd3, 4'd3, 4'd3};
`endif

    dnn_train_sched #(
        .TC(4), .EPOCHS(3), .DRAIN(2), .ETA_W(4),
        .ETA_INIT(3), .ETA_MAX(4), .ETA_STEP(1)
    ) dut (
        .cycle_clk     (cycle_clk),
        .reset         (reset),
        .start         (start),
        .pause         (pause),
        .correct       (correct),
        .tc_idx        (tc_idx),
        .epoch         (epoch),
        .etapos        (etapos),
        .feed_valid    (feed_valid),
        .busy          (busy),
        .done          (done),
        .epoch_done    (epoch_done),
        .epoch_correct (epoch_correct),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial cycle_clk = 1'b0;
    always #5 cycle_clk = ~cycle_clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge cycle_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total_cnt++;
        if ({tc_idx, epoch, etapos, feed_valid, busy, done, epoch_done, epoch_correct} !==
            {2'd0, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            $display("FAIL reset_vals: got tc=%0d ep=%0d eta=%0d fv=%b busy=%b done=%b ed=%b ec=%0d, want 0 0 3 0 0 0 0 0",
                     tc_idx, epoch, etapos, feed_valid, busy, done, epoch_done, epoch_correct);
        end else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
        else pass_cnt++;
        reset = 1'b1;
        step();
        total_cnt++;
        if ({feed_valid, busy, done} !== 3'b000)
            $display("FAIL idle_hold: got fv/busy/done=%b want 000", {feed_valid, busy, done});
        else pass_cnt++;
    endtask

    // Full run, correct=1 throughout, start pulses during RUN and DRAIN
    task automatic test_all_correct();
        correct = 1'b1;
        start = 1'b1;
        step();
        for (int t = 0; t < 15; t++) begin
            start = (t >= 3 && t <= 6) || (t == 12);
            total_cnt++;
            if ({tc_idx, epoch, feed_valid, busy, done, epoch_done} !==
                {run_tc[t], run_ep[t], run_fv[t], run_busy[t], run_done[t], run_ed[t]}) begin
                $display("FAIL all_correct_seq cyc %0d: got tc=%0d ep=%0d fv=%b busy=%b done=%b ed=%b want tc=%0d ep=%0d fv=%b busy=%b done=%b ed=%b",
                         t, tc_idx, epoch, feed_valid, busy, done, epoch_done,
                         run_tc[t], run_ep[t], run_fv[t], run_busy[t], run_done[t], run_ed[t]);
            end else pass_cnt++;
            total_cnt++;
            if (etapos !== eta_by_ep[run_ep[t]])
                $display("FAIL all_correct_eta cyc %0d: got %0d want %0d", t, etapos, eta_by_ep[run_ep[t]]);
            else pass_cnt++;
            if (run_ed[t]) begin
                total_cnt++;
                if (epoch_correct !== 3'd4)
                    $display("FAIL all_correct_count cyc %0d: got %0d want 4", t, epoch_correct);
                else pass_cnt++;
            end
            if (t == 12) begin
                total_cnt++;
                if (dbg_state !== 2'd2) $display("FAIL drain_state: got %0d want 2", dbg_state);
                else pass_cnt++;
            end
            step();
        end
        start = 1'b0;
        total_cnt++;
        if ({done, busy, feed_valid, epoch_done, epoch_correct} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd4})
            $display("FAIL done_hold: got done=%b busy=%b fv=%b ed=%b ec=%0d want 1 0 0 0 4",
                     done, busy, feed_valid, epoch_done, epoch_correct);
        else pass_cnt++;
    endtask

    // Restart from DONE, correct alternates 1,0,1,0 per epoch
    task automatic test_back_to_back();
        correct = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 15; t++) begin
            // edge closing cycle t samples the result for case t-1
            correct = (t >= 1 && t <= 12) ? (((t - 1) % 2) == 0) : 1'b0;
            total_cnt++;
            if ({tc_idx, epoch, feed_valid, busy, done, epoch_done} !==
                {run_tc[t], run_ep[t], run_fv[t], run_busy[t], run_done[t], run_ed[t]}) begin
                $display("FAIL b2b_seq cyc %0d: got tc=%0d ep=%0d fv=%b busy=%b done=%b ed=%b want tc=%0d ep=%0d fv=%b busy=%b done=%b ed=%b",
                         t, tc_idx, epoch, feed_valid, busy, done, epoch_done,
                         run_tc[t], run_ep[t], run_fv[t], run_busy[t], run_done[t], run_ed[t]);
            end else pass_cnt++;
            total_cnt++;
            if (etapos !== eta_by_ep[run_ep[t]])
                $display("FAIL b2b_eta cyc %0d: got %0d want %0d", t, etapos, eta_by_ep[run_ep[t]]);
            else pass_cnt++;
            if (run_ed[t]) begin
                total_cnt++;
                if (epoch_correct !== 3'd2)
                    $display("FAIL b2b_count cyc %0d: got %0d want 2", t, epoch_correct);
                else pass_cnt++;
            end
            step();
        end
        correct = 1'b0;
    endtask

    // Pause for 3 cycles on the last case of epoch 0
    task automatic test_pause();
        correct = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 18; t++) begin
            pause = (t >= 2 && t <= 4);
            total_cnt++;
            if ({tc_idx, epoch, feed_valid, busy, done, epoch_done} !==
                {p_tc[t], p_ep[t], p_fv[t], p_busy[t], p_done[t], p_ed[t]}) begin
                $display("FAIL pause_seq cyc %0d: got tc=%0d ep=%0d fv=%b busy=%b done=%b ed=%b want tc=%0d ep=%0d fv=%b busy=%b done=%b ed=%b",
                         t, tc_idx, epoch, feed_valid, busy, done, epoch_done,
                         p_tc[t], p_ep[t], p_fv[t], p_busy[t], p_done[t], p_ed[t]);
            end else pass_cnt++;
            total_cnt++;
            if (etapos !== eta_by_ep[p_ep[t]])
                $display("FAIL pause_eta cyc %0d: got %0d want %0d", t, etapos, eta_by_ep[p_ep[t]]);
            else pass_cnt++;
            if (p_ed[t]) begin
                total_cnt++;
                if (epoch_correct !== 3'd4)
                    $display("FAIL pause_count cyc %0d: got %0d want 4", t, epoch_correct);
                else pass_cnt++;
            end
            step();
        end
        pause = 1'b0;
        correct = 1'b0;
    endtask

    // Reset asserted at epoch 1, tc_idx 2 aborts the run
    task automatic test_reset_midrun();
        correct = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 6; t++) step();
        total_cnt++;
        if ({tc_idx, epoch, busy} !== {2'd2, 2'd1, 1'b1})
            $display("FAIL midrun_pre: got tc=%0d ep=%0d busy=%b want 2 1 1", tc_idx, epoch, busy);
        else pass_cnt++;
        reset = 1'b0;
        step();
        reset = 1'b1;
        total_cnt++;
        if ({tc_idx, epoch, etapos, feed_valid, busy, done, epoch_done, epoch_correct} !==
            {2'd0, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            $display("FAIL midrun_reset: got tc=%0d ep=%0d eta=%0d fv=%b busy=%b done=%b ed=%b ec=%0d, want 0 0 3 0 0 0 0 0",
                     tc_idx, epoch, etapos, feed_valid, busy, done, epoch_done, epoch_correct);
        end else pass_cnt++;
        for (int t = 0; t < 4; t++) begin
            step();
            total_cnt++;
            if ({feed_valid, busy, done, epoch_done, dbg_state} !== 6'b0000_00)
                $display("FAIL midrun_idle cyc %0d: got fv=%b busy=%b done=%b ed=%b st=%0d want all 0",
                         t, feed_valid, busy, done, epoch_done, dbg_state);
            else pass_cnt++;
        end
        correct = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        correct = 1'b0;
        test_reset();
        test_all_correct();
        test_back_to_back();
        test_pause();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dnn_train_sched.md
# dnn_train_sched

Training-schedule controller for the DNN datapath, clocked by the block-cycle clock. It sequences training-case indices and epochs, supplies the per-epoch learning-rate exponent, and gates valid input feeding with start/pause control. It also drains the pipeline and accumulates per-epoch correct-answer counts from the network's delayed results. It replaces the free-running training-case counter next to the DNN instance.

## Interface
Parameters:
- TC, 12544: training cases per epoch.
- EPOCHS, 10: epochs per run.
- DRAIN, 2: block cycles from feeding a case to its `correct` result being valid.
- ETA_W, 4: width of the `etapos` output.
- ETA_INIT, 3: `etapos` value at run start. The learning rate is 2^-etapos.
- ETA_MAX, 7: saturation value of `etapos`.
- ETA_STEP, 2: number of epochs between `etapos` increments.

Ports:
- cycle_clk, in, 1: block-cycle clock. All state updates on its rising edge.
- reset, in, 1: synchronous, active-low.
- start, in, 1: run request. Sampled only in IDLE or DONE.
- pause, in, 1: holds feeding while high.
- correct, in, 1: comparison result (actL matches ansL) for the case fed DRAIN cycles earlier.
- tc_idx, out, $clog2(TC): current training-case address.
- epoch, out, $clog2(EPOCHS): current epoch.
- etapos, out, ETA_W: learning-rate exponent.
- feed_valid, out, 1: `tc_idx` is a real case this block cycle.
- busy, out, 1: high in RUN or DRAIN.
- done, out, 1: high in DONE.
- epoch_done, out, 1: one-cycle pulse when `epoch_correct` updates.
- epoch_correct, out, $clog2(TC+1): correct count for the last completed epoch.

## Operation
- FSM states and transitions:
  - IDLE: goes to RUN when `start`=1.
  - RUN: goes to DRAIN after the last case of the last epoch is fed.
  - DRAIN: goes to DONE after DRAIN cycles.
  - DONE: goes to RUN when `start`=1.
- Entering RUN:
  - `tc_idx`=0, `epoch`=0, `etapos`=ETA_INIT.
  - Accumulator is cleared.
  - `feed_valid`=1 from the first RUN cycle.
- RUN with `pause`=0:
  - `tc_idx` increments each cycle.
  - At `tc_idx`=TC-1 it wraps to 0 and `epoch` increments.
  - If `epoch`=EPOCHS-1 at the wrap point, the next state is DRAIN and `tc_idx`/`epoch` hold their final values.
- RUN with `pause`=1:
  - `feed_valid`=0 and `tc_idx`/`epoch` hold.
  - Pause on the last case of an epoch defers the wrap.
- `pause` is ignored in IDLE, DRAIN and DONE.
- `start` is ignored in RUN and DRAIN.
- Result tracking uses two DRAIN-deep shift registers that shift every cycle, pause included:
  - `feed_valid`.
  - A last-case marker (feed_valid AND `tc_idx`=TC-1).
- When the delayed valid bit is 1, the accumulator adds `correct`.
- When the delayed marker is 1:
  - `epoch_correct` takes accumulator + `correct`.
  - `epoch_done` pulses.
  - The accumulator clears to 0.
- The accumulator is $clog2(TC+1) bits wide and never overflows, since it holds at most TC counts.

## Timing
- Reset values: state IDLE; `tc_idx`=0, `epoch`=0, `etapos`=ETA_INIT; `feed_valid`=0, `busy`=0, `done`=0, `epoch_done`=0, `epoch_correct`=0; shift registers and accumulator are 0.
- Reset mid-run aborts immediately to the reset values. No drain is performed.
- `start` sampled high in cycle k gives `busy`=1, `feed_valid`=1, `tc_idx`=0 in cycle k+1.
- `epoch_done` asserts DRAIN cycles after the cycle presenting `tc_idx`=TC-1 with `feed_valid`=1.
- Final-epoch `epoch_done` coincides with the last DRAIN cycle. `done` asserts the following cycle.
- All outputs are registered, with no combinational paths from inputs.

## Configuration
- SCHED_ETA_DECAY_EN defined:
  - On every epoch wrap where the new epoch number is a nonzero multiple of ETA_STEP, `etapos` increments, saturating at ETA_MAX.
- SCHED_ETA_DECAY_EN undefined:
  - `etapos` is constant at ETA_INIT and no decay logic is built.

## Test plan
Settings: TC=4, EPOCHS=3, DRAIN=2, ETA_INIT=3, ETA_MAX=4, ETA_STEP=1.
- Reset then start pulse: `tc_idx` sequence is 0,1,2,3,0,1,2,3,0,1,2,3 with `feed_valid`=1. `epoch` goes 0→1→2. DRAIN lasts 2 cycles, then `done`=1 and `busy`=0.
- `correct`=1 throughout: `epoch_done` pulses 3 times with `epoch_correct`=4. Alternating `correct` (1,0,1,0) gives `epoch_correct`=2.
- `pause` high for 3 cycles while `tc_idx`=3: `tc_idx` holds at 3 with `feed_valid`=0. The wrap and `epoch_done` each shift by 3 cycles, and the count is unchanged.
- With SCHED_ETA_DECAY_EN: `etapos` is 3, 4, 4 across the three epochs, since it saturates. Without the macro: 3, 3, 3.
- `start` asserted during RUN is ignored. `start` asserted in DONE restarts at `tc_idx`=0, `epoch`=0, `etapos`=3.
- Reset asserted at epoch 1, `tc_idx`=2: the next cycle shows IDLE reset values and no `epoch_done` pulse.
